// File: rtl/iarray_arb_pkg.sv
// Shared constants and helpers for the instruction-array read-side arbiter.
package iarray_arb_pkg;

  localparam int RDLAT_DEFAULT = 2;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/iarray_rdarb_rr_pick.sv
// Combinational round-robin pick: first active request at or above ptr, else first below it.
module rr_pick
  import iarray_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Upper pass covers ptr..NREQ-1, lower pass wraps to 0..ptr-1.
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = IDW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = IDW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iarray_rdarb.sv
// Read-port arbiter for a register-array RAM: round-robin grant, RAM address mux,
// and a valid/id pipeline aligned with the RAM read latency.
module iarray_rdarb
  import iarray_arb_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int RDLAT   = RDLAT_DEFAULT,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic                    rclk,
  input  logic                    rrst_,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*ADDRBIT-1:0] addr,
  output logic [NREQ-1:0]         gnt,
  output logic [ADDRBIT-1:0]      ra,
  output logic                    re,
  input  logic [WIDTH-1:0]        rd,
  output logic                    rvld,
  output logic [IDW-1:0]          rid,
  output logic [WIDTH-1:0]        rdata
);

  // Handshake: a read transfers on a rising rclk edge where req[i] and gnt[i]
  // are both high; the requester then drops req[i] or presents its next address.
  // The return path has no ready: rvld/rid/rdata must be taken when rvld is high.

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  pick_idx;
  logic [RDLAT-1:0] vld_pipe;
  logic [IDW-1:0]  id_pipe [RDLAT];

  // Holding the arbiter disabled during reset keeps gnt/re/ra quiet.
  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .en   (en & rrst_),
    .gnt  (gnt),
    .idx  (pick_idx)
  );

  assign re = |gnt;

  always_comb begin
    ra = '0;
    for (int i = 0; i < NREQ; i++) begin
      ra = ra | ({ADDRBIT{gnt[i]}} & addr[i*ADDRBIT +: ADDRBIT]);
    end
  end

  always_ff @(posedge rclk or negedge rrst_) begin
    if (!rrst_) begin
      ptr <= '0;
    end else if (re) begin
      ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  // Stage RDLAT-1 lines up with the RAM data for the read issued RDLAT cycles earlier.
  always_ff @(posedge rclk or negedge rrst_) begin
    if (!rrst_) begin
      vld_pipe <= '0;
      for (int i = 0; i < RDLAT; i++) id_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= re;
      id_pipe[0]  <= re ? pick_idx : '0;
      for (int i = 1; i < RDLAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign rvld  = vld_pipe[RDLAT-1];
  assign rid   = id_pipe[RDLAT-1];
  assign rdata = rd;

endmodule

// File: tb/tb_iarray_rdarb.sv
// Bench for iarray_rdarb: directed scenarios then random traffic, checked against
// a round-robin / latency reference model and a behavioural RAM.
module tb_iarray_rdarb;

  localparam int ADDRBIT = 9;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int RDLAT   = 2;
  localparam int IDW     = 2;

  // clock/reset block
  logic                    rclk  = 1'b0;
  logic                    rrst_ = 1'b0;
  logic                    en    = 1'b0;
  logic [NREQ-1:0]         req   = '0;
  logic [NREQ*ADDRBIT-1:0] addr  = '0;
  logic [NREQ-1:0]         gnt;
  logic [ADDRBIT-1:0]      ra;
  logic                    re;
  logic [WIDTH-1:0]        rd    = '0;
  logic                    rvld;
  logic [IDW-1:0]          rid;
  logic [WIDTH-1:0]        rdata;

  always #5 rclk = ~rclk;

  iarray_rdarb #(
    .ADDRBIT (ADDRBIT),
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .RDLAT   (RDLAT)
  ) dut (
    .rclk  (rclk),
    .rrst_ (rrst_),
    .en    (en),
    .req   (req),
    .addr  (addr),
    .gnt   (gnt),
    .ra    (ra),
    .re    (re),
    .rd    (rd),
    .rvld  (rvld),
    .rid   (rid),
    .rdata (rdata)
  );

  // scoreboard and reference model state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;
  logic [WIDTH-1:0]   mem [2**ADDRBIT];
  logic [ADDRBIT-1:0] ra_hist [RDLAT];
  logic [WIDTH-1:0]   exp_q[$];
  int                 exp_id_q[$];
  int                 exp_due_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Round-robin by definition: scan ptr, ptr+1, ... modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p, input logic e);
    if (!e) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // driver: one clock cycle of stimulus, checks, and model update
  task automatic step(input logic rst_n, input logic e, input logic [NREQ-1:0] r);
    int g;
    logic [ADDRBIT-1:0] ga;
    rrst_ = rst_n;
    en    = e;
    req   = r;
    if (!rst_n) begin
      mptr = 0;
      exp_q.delete();
      exp_id_q.delete();
      exp_due_q.delete();
    end
    rd = mem[ra_hist[RDLAT-1]];
    #1;
    g  = rst_n ? model_pick(r, mptr, e) : -1;
    ga = (g >= 0) ? addr[g*ADDRBIT +: ADDRBIT] : '0;
    chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("re", 32'(re), (g >= 0) ? 32'd1 : 32'd0);
    chk("ra", 32'(ra), 32'(ga));
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      chk("rvld", 32'(rvld), 32'd1);
      chk("rid", 32'(rid), 32'(exp_id_q[0]));
      chk("rdata", 32'(rdata), 32'(exp_q[0]));
      void'(exp_due_q.pop_front());
      void'(exp_id_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("rvld_idle", 32'(rvld), 32'd0);
    end
    if (!rst_n) chk("rid_rst", 32'(rid), 32'd0);
    @(posedge rclk);
    if (g >= 0) begin
      mptr = (g + 1) % NREQ;
      exp_due_q.push_back(cyc + RDLAT);
      exp_id_q.push_back(g);
      exp_q.push_back(mem[ga]);
    end
    for (int i = RDLAT - 1; i > 0; i--) ra_hist[i] = ra_hist[i-1];
    ra_hist[0] = ra;
    cyc++;
    @(negedge rclk);
  endtask

  task automatic rand_addr();
    for (int i = 0; i < NREQ; i++) addr[i*ADDRBIT +: ADDRBIT] = ADDRBIT'($urandom_range(0, 2**ADDRBIT - 1));
  endtask

  initial begin
    for (int i = 0; i < 2**ADDRBIT; i++) mem[i] = WIDTH'($urandom_range(0, 2**WIDTH - 1));
    for (int i = 0; i < RDLAT; i++) ra_hist[i] = '0;
    rand_addr();
    @(negedge rclk);

    // reset holds grants off even with requests present
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b1111);

    // all requesters held: 0,1,2,3 back to back
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000);

    // single requester granted every cycle
    addr[2*ADDRBIT +: ADDRBIT] = 9'h1A5;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0100);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 4'b0000);

    // ptr is 3 here: grant 3, then wrap to 0, then ptr=1 picks 1 from 1111
    step(1'b1, 1'b1, 4'b1001);
    step(1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000);

    // en dropped after a grant: in-flight read still returns
    step(1'b1, 1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0100);

    // reset one cycle after a grant discards that read, ptr back to 0
    step(1'b1, 1'b1, 4'b0001);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 4'b0110);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000);

    // random traffic with occasional reset and en gaps
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) rand_addr();
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 8),
           NREQ'($urandom_range(0, 2**NREQ - 1)));
    end
    for (int i = 0; i < RDLAT + 1; i++) step(1'b1, 1'b1, 4'b0000);

    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
